snn_input_loader: RTL

SNN_INPUT_LOADER -- requirements
Module: snn_input_loader

---
 rtl/snn_pkg.sv | 15 +
 rtl/snn_input_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN front end: loader FSM states and pixel geometry.
package snn_pkg;

    localparam int unsigned NUM_PIXELS_DEF = 784;
    localparam int unsigned PIX_ADDR_W     = 10;

    typedef enum logic [2:0] {
        StLoad,
        StUnpack,
        StStart,
        StWaitDone,
        StSend
    } loader_state_e;

endpackage

// File: rtl/snn_input_loader.sv
// Unpacks UART bytes into a 1-bit pixel RAM, starts the SNN core and returns its digit.
// Optional inter-byte idle timeout is enabled by defining SNN_LOADER_TIMEOUT_EN.
module snn_input_loader
    import snn_pkg::*;
#(
    parameter int unsigned NUM_PIXELS     = NUM_PIXELS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  ram_we,
    output logic [PIX_ADDR_W-1:0] ram_addr,
    output logic                  ram_data,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [3:0]            core_digit,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic                  frame_err
);

    if ((NUM_PIXELS % 8) != 0 || NUM_PIXELS == 0 || NUM_PIXELS > (1 << PIX_ADDR_W)
        || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("snn_input_loader: invalid NUM_PIXELS or TIMEOUT_CYCLES");
    end

    localparam logic [PIX_ADDR_W-1:0] LastPix = PIX_ADDR_W'(NUM_PIXELS - 1);

    loader_state_e         state_q, state_d;
    logic [PIX_ADDR_W-1:0] pixel_cnt_q, pixel_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [3:0]            digit_q, digit_d;
    logic                  tmo_expire;

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            frame_err_q;
    logic            partial;

    // Only a started frame sitting in LOAD can time out.
    assign partial    = (state_q == StLoad) && (pixel_cnt_q != '0);
    assign tmo_expire = partial && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
    assign tmo_d      = (partial && !rx_rdy && !tmo_expire) ? tmo_q + 1'b1 : '0;
    assign frame_err  = frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            tmo_q       <= tmo_d;
            frame_err_q <= tmo_expire;
        end
    end
`else
    assign tmo_expire = 1'b0;
    assign frame_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            pixel_cnt_q <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            digit_q     <= '0;
        end else begin
            state_q     <= state_d;
            pixel_cnt_q <= pixel_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            digit_q     <= digit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pixel_cnt_d = pixel_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        digit_d     = digit_q;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_data    = 1'b0;
        core_start  = 1'b0;
        tx_start    = 1'b0;

        unique case (state_q)
            StLoad: begin
                // A coincident byte still lands, but as pixel 0 of a fresh frame.
                if (tmo_expire) begin
                    pixel_cnt_d = '0;
                end
                if (rx_rdy) begin
                    shift_d   = rx_data;
                    bit_idx_d = '0;
                    state_d   = StUnpack;
                end
            end
            StUnpack: begin
                ram_we      = 1'b1;
                ram_addr    = pixel_cnt_q;
                ram_data    = shift_q[0];
                shift_d     = {1'b0, shift_q[7:1]};
                pixel_cnt_d = pixel_cnt_q + 1'b1;
                bit_idx_d   = bit_idx_q + 1'b1;
                if (bit_idx_q == 3'd7) begin
                    state_d = (pixel_cnt_q == LastPix) ? StStart : StLoad;
                end
            end
            StStart: begin
                core_start  = 1'b1;
                pixel_cnt_d = '0;
                state_d     = StWaitDone;
            end
            StWaitDone: begin
                if (core_done) begin
                    digit_d = core_digit;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    assign tx_data = {4'h0, digit_q};
    assign busy    = (state_q != StLoad);

endmodule
